// File: rtl/match_control_if.sv
// Handshake bundle between the match sequencer, the start/click logic and the round controllers.
// master drives start and round results; slave is the sequencer that publishes state and scores.
interface match_control_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic               start_as_keeper;
  logic               round_done;
  logic               is_scored;
  logic [2:0]         game_state;
  logic [SCORE_W-1:0] player_score;
  logic [SCORE_W-1:0] opp_score;
  logic [7:0]         kick_cnt;
  logic               match_over;

  modport master (
    output start, start_as_keeper, round_done, is_scored,
    input  game_state, player_score, opp_score, kick_cnt, match_over
  );

  modport slave (
    input  start, start_as_keeper, round_done, is_scored,
    output game_state, player_score, opp_score, kick_cnt, match_over
  );
endinterface

// File: rtl/match_control.sv
// Penalty-shootout sequencer: alternates keeper/shooter rounds, keeps score, ends early when decided.
// Define SUDDEN_DEATH_EN to continue tied matches in pairs instead of ending in a draw.
module match_control #(
  parameter int unsigned ROUNDS_PER_SIDE = 5,
  parameter int unsigned SCORE_W         = 4,
  parameter int unsigned GAP_TICKS       = 32500000
) (
  input logic            clk,
  input logic            rst,
  match_control_if.slave bus
);

  localparam logic [2:0] GsStart   = 3'd0;
  localparam logic [2:0] GsKeeper  = 3'd1;
  localparam logic [2:0] GsShooter = 3'd2;
  localparam logic [2:0] GsWinner  = 3'd3;
  localparam logic [2:0] GsLoser   = 3'd4;
  localparam logic [2:0] GsPause   = 3'd5;
  localparam logic [2:0] GsDraw    = 3'd6;

  localparam int unsigned        GapW     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GapW-1:0]    GapLoad  = GapW'(GAP_TICKS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;
  localparam logic [9:0]         Rps      = 10'(ROUNDS_PER_SIDE);

  typedef enum logic [2:0] {StIdle, StKeeper, StShooter, StGap, StEnd} state_e;

  state_e             state_q;
  logic [GapW-1:0]    gap_q;
  logic               last_keeper_q;
  logic [7:0]         pk_q, ok_q;
  logic [SCORE_W-1:0] player_score_q, opp_score_q;
  logic [7:0]         kick_cnt_q;
  logic [2:0]         game_state_q;
  logic               match_over_q;

  logic               is_keeper;
  logic [SCORE_W-1:0] p_nxt, o_nxt;
  logic [7:0]         pk_nxt, ok_nxt;
  logic [9:0]         p_rem, o_rem;
  logic               win, lose, draw;

  // Outcome is judged on the post-round values so the decision lands on the same edge as the score.
  always_comb begin
    is_keeper = (state_q == StKeeper);
    p_nxt     = player_score_q;
    o_nxt     = opp_score_q;
    pk_nxt    = pk_q;
    ok_nxt    = ok_q;
    if (is_keeper) begin
      if (bus.is_scored && (opp_score_q != ScoreMax)) o_nxt = opp_score_q + 1'b1;
      if (ok_q != 8'hff) ok_nxt = ok_q + 8'd1;
    end else begin
      if (bus.is_scored && (player_score_q != ScoreMax)) p_nxt = player_score_q + 1'b1;
      if (pk_q != 8'hff) pk_nxt = pk_q + 8'd1;
    end
    p_rem = (10'(pk_nxt) >= Rps) ? 10'd0 : Rps - 10'(pk_nxt);
    o_rem = (10'(ok_nxt) >= Rps) ? 10'd0 : Rps - 10'(ok_nxt);
    win   = 10'(p_nxt) > 10'(o_nxt) + o_rem;
    lose  = 10'(o_nxt) > 10'(p_nxt) + p_rem;
    draw  = 1'b0;
`ifdef SUDDEN_DEATH_EN
    // Past regulation a result only counts once both sides have kicked equally often.
    if ((10'(pk_nxt) > Rps) || (10'(ok_nxt) > Rps)) begin
      win  = (pk_nxt == ok_nxt) && (p_nxt > o_nxt);
      lose = (pk_nxt == ok_nxt) && (o_nxt > p_nxt);
    end
`else
    draw = (10'(pk_nxt) >= Rps) && (10'(ok_nxt) >= Rps) && (p_nxt == o_nxt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      gap_q          <= '0;
      last_keeper_q  <= 1'b0;
      pk_q           <= '0;
      ok_q           <= '0;
      player_score_q <= '0;
      opp_score_q    <= '0;
      kick_cnt_q     <= '0;
      game_state_q   <= GsStart;
      match_over_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StEnd: begin
          if (bus.start) begin
            pk_q           <= '0;
            ok_q           <= '0;
            player_score_q <= '0;
            opp_score_q    <= '0;
            kick_cnt_q     <= '0;
            match_over_q   <= 1'b0;
            state_q        <= bus.start_as_keeper ? StKeeper : StShooter;
            game_state_q   <= bus.start_as_keeper ? GsKeeper : GsShooter;
          end
        end
        StKeeper, StShooter: begin
          if (bus.round_done) begin
            player_score_q <= p_nxt;
            opp_score_q    <= o_nxt;
            pk_q           <= pk_nxt;
            ok_q           <= ok_nxt;
            if (kick_cnt_q != 8'hff) kick_cnt_q <= kick_cnt_q + 8'd1;
            last_keeper_q  <= is_keeper;
            if (win || lose || draw) begin
              state_q      <= StEnd;
              match_over_q <= 1'b1;
              game_state_q <= win ? GsWinner : (lose ? GsLoser : GsDraw);
            end else begin
              state_q      <= StGap;
              game_state_q <= GsPause;
              gap_q        <= GapLoad;
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_q      <= last_keeper_q ? StShooter : StKeeper;
            game_state_q <= last_keeper_q ? GsShooter : GsKeeper;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.game_state   = game_state_q;
  assign bus.player_score = player_score_q;
  assign bus.opp_score    = opp_score_q;
  assign bus.kick_cnt     = kick_cnt_q;
  assign bus.match_over   = match_over_q;

endmodule

// File: tb/tb_match_control.sv
// Directed bench for match_control; a second instance with 2-bit scores covers saturation.
module tb_match_control;
  localparam int unsigned Gap = 4;

  logic clk = 1'b0;
  logic rst, start, sak, rd, sc;
  int   checks = 0;
  int   errors = 0;

  match_control_if #(.SCORE_W(4)) bus ();
  match_control_if #(.SCORE_W(2)) bus_sat ();

  assign bus.start               = start;
  assign bus.start_as_keeper     = sak;
  assign bus.round_done          = rd;
  assign bus.is_scored           = sc;
  assign bus_sat.start           = start;
  assign bus_sat.start_as_keeper = sak;
  assign bus_sat.round_done      = rd;
  assign bus_sat.is_scored       = sc;

  match_control #(.ROUNDS_PER_SIDE(5), .SCORE_W(4), .GAP_TICKS(Gap)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  match_control #(.ROUNDS_PER_SIDE(5), .SCORE_W(2), .GAP_TICKS(Gap)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_sat)
  );

  always #5 clk = ~clk;

  // {game_state, player_score, opp_score, kick_cnt, match_over}
  function automatic logic [19:0] snap();
    return {bus.game_state, bus.player_score, bus.opp_score, bus.kick_cnt, bus.match_over};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; sak = 1'b0; rd = 1'b0; sc = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_match(input logic keeper);
    start = 1'b1; sak = keeper;
    tick();
    start = 1'b0; sak = 1'b0;
  endtask

  task automatic play_round(input logic scored);
    int n;
    rd = 1'b1; sc = scored;
    tick();
    rd = 1'b0; sc = 1'b0;
    n = 0;
    while (bus.game_state == 3'd5 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL pause_timeout: game_state %0d after %0d cycles, want pause to end", bus.game_state, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (snap() !== {3'd0, 4'd0, 4'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL reset: got %h want %h", snap(), {3'd0, 4'd0, 4'd0, 8'd0, 1'b0});
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    start_match(1'b1);
    checks++;
    if (bus.game_state !== 3'd1) begin
      errors++; $display("FAIL basic_start: game_state %0d want 1", bus.game_state);
    end
    rd = 1'b1; sc = 1'b0;
    tick();
    rd = 1'b0;
    checks++;
    if (snap() !== {3'd5, 4'd0, 4'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL basic_pause: got %h want %h", snap(), {3'd5, 4'd0, 4'd0, 8'd1, 1'b0});
    end
    n = 0;
    while (bus.game_state == 3'd5 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != Gap) begin
      errors++; $display("FAIL basic_gap_len: got %0d cycles want %0d", n, Gap);
    end
    checks++;
    if (snap() !== {3'd2, 4'd0, 4'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL basic_next: got %h want %h", snap(), {3'd2, 4'd0, 4'd0, 8'd1, 1'b0});
    end
  endtask

  task automatic test_early_win();
    logic [5:0] pat;
    logic [19:0] held;
    pat = 6'b010101;  // shooter-first: bit i is round i+1
    do_reset();
    start_match(1'b0);
    for (int i = 0; i < 5; i++) play_round(pat[i]);
    checks++;
    if (snap() !== {3'd1, 4'd3, 4'd0, 8'd5, 1'b0}) begin
      errors++; $display("FAIL win_before_last: got %h want %h", snap(), {3'd1, 4'd3, 4'd0, 8'd5, 1'b0});
    end
    play_round(pat[5]);
    held = {3'd3, 4'd3, 4'd0, 8'd6, 1'b1};
    checks++;
    if (snap() !== held) begin
      errors++; $display("FAIL win_end: got %h want %h", snap(), held);
    end
    rd = 1'b1; sc = 1'b1;
    tick();
    rd = 1'b0; sc = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (snap() !== held) begin
      errors++; $display("FAIL win_hold: got %h want %h", snap(), held);
    end
    start_match(1'b1);
    checks++;
    if (snap() !== {3'd1, 4'd0, 4'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL restart: got %h want %h", snap(), {3'd1, 4'd0, 4'd0, 8'd0, 1'b0});
    end
  endtask

  task automatic test_reg_loss();
    logic [9:0] pat;
    pat = 10'b0001111111;  // keeper-first
    do_reset();
    start_match(1'b1);
    for (int i = 0; i < 9; i++) play_round(pat[i]);
    checks++;
    if (snap() !== {3'd2, 4'd3, 4'd4, 8'd9, 1'b0}) begin
      errors++; $display("FAIL loss_round10: got %h want %h", snap(), {3'd2, 4'd3, 4'd4, 8'd9, 1'b0});
    end
    play_round(pat[9]);
    checks++;
    if (snap() !== {3'd4, 4'd3, 4'd4, 8'd10, 1'b1}) begin
      errors++; $display("FAIL loss_end: got %h want %h", snap(), {3'd4, 4'd3, 4'd4, 8'd10, 1'b1});
    end
  endtask

  task automatic test_reg_tie();
    logic [9:0] pat;
    pat = 10'b0000111111;
    do_reset();
    start_match(1'b1);
    for (int i = 0; i < 10; i++) play_round(pat[i]);
`ifdef SUDDEN_DEATH_EN
    checks++;
    if (snap() !== {3'd1, 4'd3, 4'd3, 8'd10, 1'b0}) begin
      errors++; $display("FAIL tie_sd_continue: got %h want %h", snap(), {3'd1, 4'd3, 4'd3, 8'd10, 1'b0});
    end
    play_round(1'b0);
    play_round(1'b1);
    checks++;
    if (snap() !== {3'd3, 4'd4, 4'd3, 8'd12, 1'b1}) begin
      errors++; $display("FAIL tie_sd_win: got %h want %h", snap(), {3'd3, 4'd4, 4'd3, 8'd12, 1'b1});
    end
`else
    checks++;
    if (snap() !== {3'd6, 4'd3, 4'd3, 8'd10, 1'b1}) begin
      errors++; $display("FAIL tie_draw: got %h want %h", snap(), {3'd6, 4'd3, 4'd3, 8'd10, 1'b1});
    end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    start_match(1'b1);
    for (int i = 0; i < 10; i++) play_round(1'b1);
`ifdef SUDDEN_DEATH_EN
    play_round(1'b1);
    play_round(1'b1);
    checks++;
    if (bus_sat.game_state !== 3'd1 || bus_sat.kick_cnt !== 8'd12) begin
      errors++; $display("FAIL sat_state: state %0d kicks %0d want 1 12", bus_sat.game_state, bus_sat.kick_cnt);
    end
`else
    checks++;
    if (bus_sat.game_state !== 3'd6 || bus_sat.kick_cnt !== 8'd10) begin
      errors++; $display("FAIL sat_state: state %0d kicks %0d want 6 10", bus_sat.game_state, bus_sat.kick_cnt);
    end
    checks++;
    if (bus.player_score !== 4'd5 || bus.opp_score !== 4'd5) begin
      errors++; $display("FAIL wide_scores: got %0d-%0d want 5-5", bus.player_score, bus.opp_score);
    end
`endif
    checks++;
    if (bus_sat.player_score !== 2'd3 || bus_sat.opp_score !== 2'd3) begin
      errors++; $display("FAIL sat_scores: got %0d-%0d want 3-3", bus_sat.player_score, bus_sat.opp_score);
    end
  endtask

  task automatic test_ignored();
    int n;
    do_reset();
    start_match(1'b1);
    sc = 1'b1;
    tick(); tick();
    sc = 1'b0;
    start = 1'b1; sak = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (snap() !== {3'd1, 4'd0, 4'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL ign_round: got %h want %h", snap(), {3'd1, 4'd0, 4'd0, 8'd0, 1'b0});
    end
    rd = 1'b1; sc = 1'b0;
    tick();
    rd = 1'b1; sc = 1'b1;  // second pulse lands in the gap
    tick();
    rd = 1'b0; sc = 1'b0;
    checks++;
    if (snap() !== {3'd5, 4'd0, 4'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL ign_gap: got %h want %h", snap(), {3'd5, 4'd0, 4'd0, 8'd1, 1'b0});
    end
    n = 0;
    while (bus.game_state == 3'd5 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (snap() !== {3'd2, 4'd0, 4'd0, 8'd1, 1'b0} || n != Gap - 1) begin
      errors++; $display("FAIL ign_alternate: got %h after %0d want %h after %0d", snap(), n,
                         {3'd2, 4'd0, 4'd0, 8'd1, 1'b0}, Gap - 1);
    end
    rd = 1'b1; sc = 1'b1;
    tick();
    rd = 1'b0; sc = 1'b0;
    tick();
    checks++;
    if (snap() !== {3'd5, 4'd1, 4'd0, 8'd2, 1'b0}) begin
      errors++; $display("FAIL ign_score: got %h want %h", snap(), {3'd5, 4'd1, 4'd0, 8'd2, 1'b0});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (snap() !== {3'd0, 4'd0, 4'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL gap_reset: got %h want %h", snap(), {3'd0, 4'd0, 4'd0, 8'd0, 1'b0});
    end
    for (int i = 0; i < Gap + 2; i++) tick();
    checks++;
    if (snap() !== {3'd0, 4'd0, 4'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL idle_hold: got %h want %h", snap(), {3'd0, 4'd0, 4'd0, 8'd0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_win();
    test_reg_loss();
    test_reg_tie();
    test_saturation();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/match_control.md
Name: match_control

Overview:
- Penalty-shootout sequencer. Decides which round type runs next and drives the 3-bit game_state bus read by the keeper (gloves) and shooter round controllers.
- Collects each round's round_done/is_scored result, keeps both scores, and ends the match early once the result is mathematically decided.
- Sits between the start screen / mouse-click logic and the per-round controllers. Its outputs also feed the score overlay.

Parameters:
- ROUNDS_PER_SIDE, 5: regulation kicks per side.
- SCORE_W, 4: width of each score counter; counters saturate.
- GAP_TICKS, 32500000: PAUSE duration between rounds in clk cycles (0.5 s at 65 MHz). Must be >= 1.

Ports:
- clk  in  1  system clock, 65 MHz
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse that begins a new match
- start_as_keeper  in  1  sampled with start; 1 means the first round is KEEPER
- round_done  in  1  one-cycle pulse from the active round controller
- is_scored  in  1  valid only together with round_done; 1 means a goal was scored in that round
- game_state  out  3  0=START, 1=KEEPER, 2=SHOOTER, 3=WINNER, 4=LOSER, 5=PAUSE, 6=DRAW
- player_score  out  SCORE_W  goals scored by the player
- opp_score  out  SCORE_W  goals scored against the player
- kick_cnt  out  8  completed rounds in this match; saturates at 255
- match_over  out  1  high while in the END state

Behaviour:
- Reset value of every output: game_state=START, both scores=0, kick_cnt=0, match_over=0. State=IDLE, gap counter=0. All outputs are registered.
- States: IDLE, KEEPER_RND, SHOOTER_RND, GAP, END.
- IDLE:
  - start=1 clears scores and kick_cnt.
  - Next state is KEEPER_RND if start_as_keeper=1, otherwise SHOOTER_RND. game_state updates on the same edge, so there is 1-cycle latency from start.
- KEEPER_RND / SHOOTER_RND:
  - Hold game_state at KEEPER or SHOOTER until round_done.
  - On round_done (cycle N), at edge N+1:
    - KEEPER round with is_scored=1: opp_score+1.
    - SHOOTER round with is_scored=1: player_score+1.
    - kick_cnt+1 in either case.
    - Decision is made from the updated values, evaluated combinationally in cycle N.
  - Per-side kicks taken: a side's count increments on each of its own rounds. Remaining kicks = ROUNDS_PER_SIDE minus kicks taken, floored at 0.
  - Win: player_score > opp_score + opp_remaining, and not in sudden death. Next state END, game_state=WINNER.
  - Loss: opp_score > player_score + player_remaining. Next state END, game_state=LOSER.
  - All regulation kicks taken: outcome depends on the scores and the optional feature.
  - Otherwise: next state GAP, game_state=PAUSE, gap counter loaded with GAP_TICKS-1.
- GAP:
  - Decrement the counter each cycle. game_state stays PAUSE for exactly GAP_TICKS cycles.
  - At 0, enter the other round type, which alternates strictly.
  - PAUSE guarantees the round controllers see a non-KEEPER/SHOOTER value between rounds, so they do not retrigger.
- END:
  - game_state holds WINNER, LOSER or DRAW; match_over=1.
  - start=1 behaves as in IDLE: the new match starts on the next edge.
- Ignored inputs:
  - round_done in IDLE, GAP or END.
  - is_scored without round_done.
  - start in any round or GAP state.
- Score counters saturate at 2^SCORE_W-1; a decision already taken is not reversed.
- rst has priority over every input in every state, including mid-round and mid-gap.

Optional Feature:
- Macro: SUDDEN_DEATH_EN.
- Defined:
  - Tie after regulation continues in pairs of rounds, alternating as before.
  - Decision is made only after both sides have taken equal kicks. Unequal scores give WINNER or LOSER; equal scores give GAP and the next pair.
  - Early-win checks use remaining=0 during sudden death.
- Undefined: tie after regulation goes to END with game_state=DRAW. Code 6 is never produced when the macro is defined.

Test Plan:
- Basic start: GAP_TICKS=4, start with start_as_keeper=1 -> game_state=1 next cycle. round_done, is_scored=0 -> PAUSE for exactly 4 cycles, then 2. kick_cnt=1.
- Early win: shooter-first, player scores 3 times, opponent 0 after 3 pairs of regulation kicks -> WINNER; match_over=1; game_state=3; kick_cnt=6. No further rounds.
- Regulation loss: all 10 kicks, opponent 4, player 3 -> LOSER after the 10th round_done; game_state=4.
- Regulation tie: all 10 kicks, 3-3 -> DRAW (6) without SUDDEN_DEATH_EN. With the macro: round 11 starts after PAUSE; pair 11/12 ends 4-3 -> WINNER.
- Ignored inputs: round_done during GAP and start during KEEPER_RND -> no score, count or state change. rst asserted mid-GAP -> all outputs return to reset values on the next edge.
- Saturation: SCORE_W=2 with sudden death, force 4 goals -> score holds at 3.
